// File: rtl/lcd_frame_sequencer_if.sv
// Shared types and the signal bundle between the LCD frame sequencer and its neighbours:
// request source, board memory, command LUT and LCD pins.
package lcd_seq_pkg;
    typedef enum logic [2:0] {IDLE, SET_I, SEND_I, SET, SEND} update_t;

    typedef enum logic [2:0] {
        S_IDLE, S_I_SET, S_I_SEND, S_FETCH, S_FETCH_W, S_C_SET, S_C_SEND, S_NEXT
    } state_t;

    typedef struct packed {
        state_t state;
        logic   inited;
        logic   pend_init;
        logic   pend_redraw;
    } seq_dbg_t;
endpackage

interface lcd_frame_sequencer_if;
    import lcd_seq_pkg::*;

    logic       init_req;
    logic       redraw_req;
    logic       cmd_finished;
    logic       pause;
    logic       mem_rd;
    logic [3:0] mem_x;
    logic [3:0] mem_y;
    logic [2:0] mem_code;
    update_t    mode;
    logic [3:0] X;
    logic [3:0] Y;
    logic [2:0] obj_code;
    logic       wrx;
    logic       csx;
    logic       busy;
    logic       frame_done;

    modport master (
        input  init_req, redraw_req, cmd_finished, pause, mem_code,
        output mem_rd, mem_x, mem_y, mode, X, Y, obj_code, wrx, csx, busy, frame_done
    );

    modport slave (
        output init_req, redraw_req, cmd_finished, pause, mem_code,
        input  mem_rd, mem_x, mem_y, mode, X, Y, obj_code, wrx, csx, busy, frame_done
    );
endinterface

// File: rtl/lcd_frame_sequencer.sv
// Runs the LCD init sequence once, then redraws the object grid cell by cell on request,
// fetching each cell's code from board memory and strobing wrx/csx for every LUT byte.
module lcd_frame_sequencer
    import lcd_seq_pkg::*;
#(
    parameter int GRID_W  = 12,
    parameter int GRID_H  = 16,
    parameter int WR_LOW  = 1,
    parameter int WR_HIGH = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    lcd_frame_sequencer_if.master        bus,
    output seq_dbg_t                     dbg
);
    localparam int            BYTE_CYC = WR_LOW + WR_HIGH;
    localparam int            CW       = $clog2(BYTE_CYC + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(BYTE_CYC - 1);
    localparam logic [CW-1:0] LOW_CNT  = CW'(WR_LOW);
    localparam logic [3:0]    X_LAST   = 4'(GRID_W - 1);
    localparam logic [3:0]    Y_LAST   = 4'(GRID_H - 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    x_q, x_n, y_q, y_n, mem_x_q, mem_y_q;
    logic [2:0]    obj_q, obj_n;
    logic          wrx_q, csx_q, mem_rd_q, busy_q, done_q, done_n;
    logic          pend_init, pend_redraw, inited, inited_n;
    logic          clr_init, clr_redraw, in_send_n;
    update_t       mode_c;

    // Memory handshake: mem_rd is a one-cycle request with no backpressure; mem_code is
    // taken unconditionally in FETCH_W, exactly one cycle after mem_rd.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        x_n        = x_q;
        y_n        = y_q;
        obj_n      = obj_q;
        done_n     = 1'b0;
        inited_n   = inited;
        clr_init   = 1'b0;
        clr_redraw = 1'b0;
        case (state)
            S_IDLE: begin
                if (pend_init || (pend_redraw && !inited)) begin
                    state_n = S_I_SET;
                end else if (pend_redraw) begin
                    clr_redraw = 1'b1;
                    x_n        = 4'd0;
                    y_n        = 4'd0;
                    state_n    = S_FETCH;
                end
            end
            S_I_SET: begin
                if (!bus.pause) begin
                    state_n = S_I_SEND;
                    cnt_n   = '0;
                end
            end
            S_I_SEND: begin
                if (cnt == LAST_CNT) begin
                    if (bus.cmd_finished) begin
                        inited_n = 1'b1;
                        clr_init = 1'b1;
                        state_n  = S_IDLE;
                    end else begin
                        state_n = S_I_SET;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_FETCH:   state_n = S_FETCH_W;
            S_FETCH_W: begin
                obj_n   = bus.mem_code;
                state_n = S_C_SET;
            end
            S_C_SET: begin
                state_n = S_C_SEND;
                cnt_n   = '0;
            end
            S_C_SEND: begin
                if (cnt == LAST_CNT) begin
                    state_n = bus.cmd_finished ? S_NEXT : S_C_SET;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_NEXT: begin
                state_n = S_FETCH;
                if (x_q == X_LAST) begin
                    x_n = 4'd0;
                    if (y_q == Y_LAST) begin
                        y_n     = 4'd0;
                        done_n  = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        y_n = y_q + 4'd1;
                    end
                end else begin
                    x_n = x_q + 4'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign in_send_n = (state_n == S_I_SEND) || (state_n == S_C_SEND);

    // Registered outputs are computed from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            x_q         <= 4'd0;
            y_q         <= 4'd0;
            obj_q       <= 3'd0;
            mem_x_q     <= 4'd0;
            mem_y_q     <= 4'd0;
            wrx_q       <= 1'b1;
            csx_q       <= 1'b1;
            mem_rd_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pend_init   <= 1'b0;
            pend_redraw <= 1'b0;
            inited      <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            x_q         <= x_n;
            y_q         <= y_n;
            obj_q       <= obj_n;
            wrx_q       <= !(in_send_n && (cnt_n < LOW_CNT));
            csx_q       <= (state_n == S_IDLE);
            mem_rd_q    <= (state_n == S_FETCH);
            busy_q      <= (state_n != S_IDLE);
            done_q      <= done_n;
            inited      <= inited_n;
            pend_init   <= (pend_init && !clr_init) || bus.init_req;
            pend_redraw <= (pend_redraw && !clr_redraw) || bus.redraw_req;
            if (state_n == S_FETCH) begin
                mem_x_q <= x_n;
                mem_y_q <= y_n;
            end
        end
    end

    always_comb begin
        mode_c = IDLE;
        case (state)
            S_I_SET:  mode_c = SET_I;
            S_I_SEND: mode_c = SEND_I;
            S_C_SET:  mode_c = SET;
            S_C_SEND: mode_c = SEND;
            default:  mode_c = IDLE;
        endcase
    end

    assign bus.mode       = mode_c;
    assign bus.X          = x_q;
    assign bus.Y          = y_q;
    assign bus.obj_code   = obj_q;
    assign bus.wrx        = wrx_q;
    assign bus.csx        = csx_q;
    assign bus.mem_rd     = mem_rd_q;
    assign bus.mem_x      = mem_x_q;
    assign bus.mem_y      = mem_y_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;

    assign dbg.state       = state;
    assign dbg.inited      = inited;
    assign dbg.pend_init   = pend_init;
    assign dbg.pend_redraw = pend_redraw;
endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Bench for lcd_frame_sequencer: cycle-exact vector table, then randomized request
// scenarios checked against a job-level model of init/frame ordering and byte streams.
module tb_lcd_frame_sequencer;
    import lcd_seq_pkg::*;

    localparam int GW       = 3;
    localparam int GH       = 2;
    localparam int WL       = 2;
    localparam int WH       = 3;
    localparam int INIT_LEN = 4;
    localparam int TIMEOUT  = 20000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       t_rst, t_ir, t_rr, t_cf, t_pz;
    logic [2:0] t_mc;
    logic       m_cf, m_pz;
    logic [2:0] m_mc;
    logic       auto_drv, mon_en;
    seq_dbg_t   dbg;

    lcd_frame_sequencer_if bus();

    assign bus.init_req     = t_ir;
    assign bus.redraw_req   = t_rr;
    assign bus.cmd_finished = auto_drv ? m_cf : t_cf;
    assign bus.pause        = auto_drv ? m_pz : t_pz;
    assign bus.mem_code     = auto_drv ? m_mc : t_mc;

    lcd_frame_sequencer #(.GRID_W(GW), .GRID_H(GH), .WR_LOW(WL), .WR_HIGH(WH)) dut (
        .clk (clk),
        .rst (t_rst),
        .bus (bus),
        .dbg (dbg)
    );

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          ev_seen = 0;
    logic        m_inited;
    int          cell_len;
    logic [2:0]  mem_arr [GH][GW];

    function automatic logic [15:0] ev(input logic [1:0] k, input logic [3:0] x,
                                       input logic [3:0] y, input logic [2:0] o);
        return {k, x, y, o, 3'b000};
    endfunction

    task automatic sb_check(input string name, input logic [15:0] got);
        logic [15:0] e;
        vec_cnt++;
        ev_seen++;
        if (exp_q.size() == 0) begin
            err_cnt++;
            $display("FAIL %s: got event %h, expected no event", name, got);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                err_cnt++;
                $display("FAIL %s: got event %h, expected %h", name, got, e);
            end
        end
    endtask

    task automatic check_val(input string name, input int got, input int expv);
        vec_cnt++;
        if (got != expv) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", name, got, expv);
        end
    endtask

    // Job-level reference: an init job is 4 bytes; a frame visits cells row-major,
    // each cell is one memory read followed by cell_len bytes, then one frame_done.
    task automatic push_init();
        for (int i = 0; i < INIT_LEN; i++) exp_q.push_back(ev(2'd0, 4'd0, 4'd0, 3'd0));
    endtask

    task automatic push_frame();
        for (int y = 0; y < GH; y++) begin
            for (int x = 0; x < GW; x++) begin
                exp_q.push_back(ev(2'd2, 4'(x), 4'(y), 3'd0));
                for (int b = 0; b < cell_len; b++)
                    exp_q.push_back(ev(2'd1, 4'(x), 4'(y), mem_arr[y][x]));
            end
        end
        exp_q.push_back(ev(2'd3, 4'd0, 4'd0, 3'd0));
    endtask

    // ---------------- monitor + LUT / memory models ----------------
    logic prev_wrx, was_pause, rd_pend;
    int   low_run, done_cnt, pause_left, rd_x, rd_y, seq_len;

    always @(negedge clk) begin
        if (t_rst || !mon_en) begin
            prev_wrx = 1'b1; was_pause = 1'b0; rd_pend = 1'b0;
            low_run = 0; done_cnt = 0; pause_left = 0; rd_x = 0; rd_y = 0;
            m_cf = 1'b0; m_pz = 1'b0; m_mc = 3'd0;
        end else begin
            if (was_pause)
                check_val("pause_hold", int'({bus.wrx, bus.mode == SET_I}), 3);
            if (!bus.wrx) low_run++;
            if (!prev_wrx && bus.wrx) begin
                check_val("wrx_low", low_run, WL);
                if (bus.mode == SEND_I) sb_check("init_byte", ev(2'd0, 4'd0, 4'd0, 3'd0));
                else sb_check("cell_byte", ev(2'd1, bus.X, bus.Y, bus.obj_code));
                low_run = 0;
                done_cnt++;
                if (bus.mode == SEND_I && (done_cnt == 1 || done_cnt == 3))
                    pause_left = $urandom_range(2, 6);
            end
            if (bus.mem_rd) sb_check("mem_rd", ev(2'd2, bus.mem_x, bus.mem_y, 3'd0));
            if (bus.frame_done) sb_check("frame_done", ev(2'd3, 4'd0, 4'd0, 3'd0));
            prev_wrx = bus.wrx;
            if (bus.mode == IDLE) done_cnt = 0;
            if (bus.mode == SET_I && pause_left > 0) pause_left--;
            m_pz      = (pause_left > 0);
            was_pause = m_pz && (bus.mode == SET_I);
            seq_len   = (bus.mode == SET_I || bus.mode == SEND_I) ? INIT_LEN : cell_len;
            m_cf      = (done_cnt >= seq_len);
            if (rd_pend && rd_x < GW && rd_y < GH) m_mc = mem_arr[rd_y][rd_x];
            else m_mc = 3'($urandom);
            rd_pend = bus.mem_rd;
            rd_x    = int'(bus.mem_x);
            rd_y    = int'(bus.mem_y);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        t_rst = 1'b1;
        repeat (2) @(negedge clk);
        t_rst = 1'b0;
    endtask

    task automatic pulse(input logic ir, input logic rr);
        @(negedge clk);
        t_ir = ir;
        t_rr = rr;
        @(negedge clk);
        t_ir = 1'b0;
        t_rr = 1'b0;
    endtask

    task automatic recover();
        mon_en = 1'b0;
        do_reset();
        exp_q.delete();
        m_inited = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic wait_events(input int target);
        int n = 0;
        while (ev_seen < target && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        vec_cnt++;
        if (n >= TIMEOUT) begin
            err_cnt++;
            $display("FAIL timeout: %0d events outstanding, busy=%b", exp_q.size(), bus.busy);
            recover();
        end else begin
            repeat (3) @(negedge clk);
            check_val("idle_busy", int'(bus.busy), 0);
            check_val("inited", int'(dbg.inited), int'(m_inited));
        end
    endtask

    // 0 init, 1 redraw, 2 both, 3 redraw+mid redraw, 4 redraw+mid init, 5 init+mid redraw
    task automatic run_scenario(input int p);
        int base, k;
        cell_len = $urandom_range(1, 4);
        for (int y = 0; y < GH; y++)
            for (int x = 0; x < GW; x++) mem_arr[y][x] = 3'($urandom);
        base = ev_seen;
        k = 0;
        if (p == 0 || p == 2 || p == 5 || !m_inited) begin
            push_init();
            k = INIT_LEN;
        end
        m_inited = 1'b1;
        case (p)
            0: pulse(1'b1, 1'b0);
            1: begin push_frame(); pulse(1'b0, 1'b1); end
            2: begin push_frame(); pulse(1'b1, 1'b1); end
            3: begin
                push_frame(); push_frame();
                pulse(1'b0, 1'b1);
                wait_events(base + k + 1);
                pulse(1'b0, 1'b1);
            end
            4: begin
                push_frame(); push_init();
                pulse(1'b0, 1'b1);
                wait_events(base + k + 1);
                pulse(1'b1, 1'b0);
            end
            default: begin
                push_frame();
                pulse(1'b1, 1'b0);
                wait_events(base + 1);
                pulse(1'b0, 1'b1);
            end
        endcase
        wait_idle();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       rst, ir, rr, cf, pz;
        logic [2:0] mc;
        update_t    mode;
        logic       busy, wrx, csx, rd;
        logic [2:0] obj;
        logic       inited;
    } vec_t;

    function automatic vec_t mk(input logic r, ir, rr, cf, pz, input logic [2:0] mc,
                                input update_t m, input logic b, w, c, rd,
                                input logic [2:0] ob, input logic in);
        vec_t v;
        v.rst = r; v.ir = ir; v.rr = rr; v.cf = cf; v.pz = pz; v.mc = mc;
        v.mode = m; v.busy = b; v.wrx = w; v.csx = c; v.rd = rd; v.obj = ob; v.inited = in;
        return v;
    endfunction

    vec_t        tv[18];
    logic [18:0] got_v, exp_v;

    initial begin
        t_rst = 1'b1; t_ir = 1'b0; t_rr = 1'b0; t_cf = 1'b0; t_pz = 1'b0; t_mc = 3'd0;
        auto_drv = 1'b0; mon_en = 1'b0; m_inited = 1'b0; cell_len = 1;
        for (int y = 0; y < GH; y++)
            for (int x = 0; x < GW; x++) mem_arr[y][x] = 3'd0;
        repeat (2) @(negedge clk);
        t_rst = 1'b0;

        // Expected outputs are those seen before the edge; inputs are sampled at that edge.
        //             rst ir  rr  cf  pz  mc    mode    bsy wrx csx rd  obj inited
        tv[0]  = mk(0, 1, 0, 0, 1, 3'd0, IDLE,   0, 1, 1, 0, 3'd0, 0);
        tv[1]  = mk(0, 0, 0, 0, 1, 3'd0, IDLE,   0, 1, 1, 0, 3'd0, 0);
        tv[2]  = mk(0, 0, 0, 0, 1, 3'd0, SET_I,  1, 1, 0, 0, 3'd0, 0);
        tv[3]  = mk(0, 0, 0, 0, 0, 3'd0, SET_I,  1, 1, 0, 0, 3'd0, 0);
        tv[4]  = mk(0, 0, 0, 0, 0, 3'd0, SEND_I, 1, 0, 0, 0, 3'd0, 0);
        tv[5]  = mk(0, 0, 0, 0, 0, 3'd0, SEND_I, 1, 0, 0, 0, 3'd0, 0);
        tv[6]  = mk(0, 0, 0, 0, 0, 3'd0, SEND_I, 1, 1, 0, 0, 3'd0, 0);
        tv[7]  = mk(0, 0, 0, 0, 0, 3'd0, SEND_I, 1, 1, 0, 0, 3'd0, 0);
        tv[8]  = mk(0, 0, 0, 1, 0, 3'd0, SEND_I, 1, 1, 0, 0, 3'd0, 0);
        tv[9]  = mk(0, 0, 1, 0, 0, 3'd0, IDLE,   0, 1, 1, 0, 3'd0, 1);
        tv[10] = mk(0, 0, 0, 0, 0, 3'd0, IDLE,   0, 1, 1, 0, 3'd0, 1);
        tv[11] = mk(0, 0, 0, 0, 0, 3'd2, IDLE,   1, 1, 0, 1, 3'd0, 1);
        tv[12] = mk(0, 0, 0, 0, 0, 3'd5, IDLE,   1, 1, 0, 0, 3'd0, 1);
        tv[13] = mk(0, 0, 0, 0, 0, 3'd0, SET,    1, 1, 0, 0, 3'd5, 1);
        tv[14] = mk(1, 0, 0, 0, 0, 3'd0, SEND,   1, 0, 0, 0, 3'd5, 1);
        tv[15] = mk(0, 0, 1, 0, 0, 3'd0, IDLE,   0, 1, 1, 0, 3'd0, 0);
        tv[16] = mk(0, 0, 0, 0, 0, 3'd0, IDLE,   0, 1, 1, 0, 3'd0, 0);
        tv[17] = mk(1, 0, 0, 0, 0, 3'd0, SET_I,  1, 1, 0, 0, 3'd0, 0);

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            got_v = {bus.mode, bus.busy, bus.wrx, bus.csx, bus.mem_rd, bus.obj_code,
                     bus.X, bus.Y, dbg.inited};
            exp_v = {tv[i].mode, tv[i].busy, tv[i].wrx, tv[i].csx, tv[i].rd, tv[i].obj,
                     8'h00, tv[i].inited};
            vec_cnt++;
            if (got_v !== exp_v) begin
                err_cnt++;
                $display("FAIL vec[%0d]: got %h, expected %h (mode,busy,wrx,csx,mem_rd,obj,X,Y,inited)",
                         i, got_v, exp_v);
            end
            t_rst = tv[i].rst; t_ir = tv[i].ir; t_rr = tv[i].rr;
            t_cf = tv[i].cf; t_pz = tv[i].pz; t_mc = tv[i].mc;
        end
        t_rst = 1'b0; t_ir = 1'b0; t_rr = 1'b0; t_cf = 1'b0; t_pz = 1'b0;

        do_reset();
        m_inited = 1'b0;
        auto_drv = 1'b1;
        mon_en   = 1'b1;

        for (int p = 1; p <= 5; p++) run_scenario(p);
        run_scenario(0);
        for (int s = 0; s < 24; s++) run_scenario($urandom_range(0, 5));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
